// File: rtl/alu_issue.sv
// Command buffer that feeds an external combinational add/sub unit and
// registers one result per cycle behind a valid/ready handshake.
`timescale 1ns/1ps
module alu_issue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             cmd_sub,
   output logic [WIDTH-1:0] op_x,
   output logic [WIDTH-1:0] op_y,
   output logic             op_sign,
   input  logic [WIDTH-1:0] op_z,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_res,
   input  logic             flush,
   output logic [15:0]      done_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

   logic [WIDTH-1:0] mem_a [DEPTH];
   logic [WIDTH-1:0] mem_b [DEPTH];
   logic             mem_s [DEPTH];

   logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
   logic             rsp_valid_reg;
   logic [WIDTH-1:0] rsp_res_reg;
   logic [15:0]      done_cnt_reg;
   state_t           state_reg, state_next;

   logic full, empty, accept, issue, consume;

   // Extra pointer bit distinguishes full (MSBs differ) from empty (equal).
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign accept  = cmd_valid && !full && !flush;
   assign issue   = !empty && (!rsp_valid_reg || rsp_ready) && !flush;
   assign consume = rsp_valid_reg && rsp_ready;

   assign cmd_ready = !full;
   assign op_x      = empty ? '0   : mem_a[rd_ptr_reg[AW-1:0]];
   assign op_y      = empty ? '0   : mem_b[rd_ptr_reg[AW-1:0]];
   assign op_sign   = empty ? 1'b0 : mem_s[rd_ptr_reg[AW-1:0]];
   assign rsp_valid = rsp_valid_reg;
   assign rsp_res   = rsp_res_reg;
   assign done_cnt  = done_cnt_reg;

   always_ff @(posedge clk) begin
      if (accept) begin
         mem_a[wr_ptr_reg[AW-1:0]] <= cmd_a;
         mem_b[wr_ptr_reg[AW-1:0]] <= cmd_b;
         mem_s[wr_ptr_reg[AW-1:0]] <= cmd_sub;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_res_reg   <= '0;
         done_cnt_reg  <= 16'd0;
         state_reg     <= IDLE;
      end else begin
         state_reg <= state_next;
         // A consume still counts on a flush edge; everything else is dropped.
         if (consume)
            done_cnt_reg <= done_cnt_reg + 16'd1;
         if (flush) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            rsp_valid_reg <= 1'b0;
         end else begin
            if (accept)
               wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (issue) begin
               rd_ptr_reg    <= rd_ptr_reg + PTR_ONE;
               rsp_res_reg   <= op_z;
               rsp_valid_reg <= 1'b1;
            end else if (rsp_ready) begin
               rsp_valid_reg <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    if (accept) state_next = RUN;
            RUN: begin
               if (rsp_valid_reg && !rsp_ready && !empty)
                  state_next = STALL;
               else if (empty && !accept && (!rsp_valid_reg || rsp_ready))
                  state_next = IDLE;
            end
            STALL:   if (rsp_ready) state_next = RUN;
            default: state_next = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: vector table, directed corner cases and
// randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_alu_issue;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid, cmd_ready, cmd_sub, op_sign;
   logic [WIDTH-1:0] cmd_a, cmd_b, op_x, op_y, op_z, rsp_res;
   logic             rsp_valid, rsp_ready, flush;
   logic [15:0]      done_cnt;

   alu_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sub(cmd_sub),
      .op_x(op_x), .op_y(op_y), .op_sign(op_sign), .op_z(op_z),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
      .flush(flush), .done_cnt(done_cnt)
   );

   always #5 clk = ~clk;

   // External add/sub unit.
   assign op_z = op_sign ? (op_x - op_y) : (op_x + op_y);

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
   } cmd_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic [7:0] exp;
   } vec_t;

   cmd_t        mq[$];
   logic        m_valid;
   logic [7:0]  m_res;
   logic [15:0] m_done;
   logic        m_acc;
   int          n_tests = 0;
   int          n_fail  = 0;

   function automatic logic [7:0] calc(input cmd_t c);
      logic [7:0] r;
      r = c.sub ? (c.a - c.b) : (c.a + c.b);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_valid = 1'b0;
      m_res   = 8'h00;
      m_done  = 16'h0000;
      m_acc   = 1'b0;
   endtask

   task automatic check_model();
      logic [7:0] ex_x, ex_y;
      logic       ex_s;
      ex_x = (mq.size() != 0) ? mq[0].a   : 8'h00;
      ex_y = (mq.size() != 0) ? mq[0].b   : 8'h00;
      ex_s = (mq.size() != 0) ? mq[0].sub : 1'b0;
      chk("cmd_ready", cmd_ready, (mq.size() < DEPTH));
      chk("rsp_valid", rsp_valid, m_valid);
      chk("rsp_res", rsp_res, m_res);
      chk("done_cnt", done_cnt, m_done);
      chk("op_x", op_x, ex_x);
      chk("op_y", op_y, ex_y);
      chk("op_sign", op_sign, ex_s);
   endtask

   task automatic model_update();
      logic full_m, acc, iss, cons;
      cmd_t c;
      full_m = (mq.size() == DEPTH);
      acc    = cmd_valid && !full_m && !flush;
      iss    = (mq.size() != 0) && (!m_valid || rsp_ready) && !flush;
      cons   = m_valid && rsp_ready;
      m_acc  = acc;
      if (cons) m_done = m_done + 16'd1;
      if (flush) begin
         mq.delete();
         m_valid = 1'b0;
      end else begin
         if (iss) begin
            c       = mq.pop_front();
            m_res   = calc(c);
            m_valid = 1'b1;
         end else if (rsp_ready) begin
            m_valid = 1'b0;
         end
         if (acc) begin
            c.a = cmd_a; c.b = cmd_b; c.sub = cmd_sub;
            mq.push_back(c);
         end
      end
   endtask

   // Called at a falling edge with inputs already set.
   task automatic cycle();
      #1;
      check_model();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic set_cmd(input logic v, input cmd_t c);
      cmd_valid = v; cmd_a = c.a; cmd_b = c.b; cmd_sub = c.sub;
   endtask

   function automatic cmd_t rand_cmd();
      cmd_t c;
      c.a = 8'($urandom); c.b = 8'($urandom); c.sub = 1'($urandom);
      return c;
   endfunction

   vec_t        vt[7];
   cmd_t        bp[5];
   cmd_t        st[16];
   cmd_t        c;
   logic [15:0] d0;
   int          k;

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sub = 1'b0;
      rsp_ready = 1'b0; flush = 1'b0;
      model_reset();
      @(negedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_res", rsp_res, 0);
      chk("rst_done_cnt", done_cnt, 0);
      chk("rst_op_x", op_x, 0);
      chk("rst_op_sign", op_sign, 0);
      rst = 1'b0;

      // Single-command vectors with free output.
      vt[0] = '{8'h05, 8'h07, 1'b0, 8'h0C};
      vt[1] = '{8'h03, 8'h05, 1'b1, 8'hFE};
      vt[2] = '{8'hFF, 8'h01, 1'b0, 8'h00};
      vt[3] = '{8'h80, 8'h80, 1'b0, 8'h00};
      vt[4] = '{8'h00, 8'h01, 1'b1, 8'hFF};
      vt[5] = '{8'h7F, 8'h01, 1'b0, 8'h80};
      vt[6] = '{8'h10, 8'h10, 1'b1, 8'h00};
      rsp_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         c.a = vt[i].a; c.b = vt[i].b; c.sub = vt[i].sub;
         set_cmd(1'b1, c);
         cycle();
         cmd_valid = 1'b0;
         chk("vec_no_bypass", rsp_valid, 0);
         cycle();
         chk("vec_valid", rsp_valid, 1);
         chk("vec_res", rsp_res, vt[i].exp);
         cycle();
         chk("vec_clear", rsp_valid, 0);
      end
      chk("vec_done_cnt", done_cnt, 7);

      // Backpressure: output blocked, FIFO fills, then drains in order.
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) bp[i] = rand_cmd();
      k = 0;
      for (int i = 0; i < 8; i++) begin
         set_cmd(1'b1, bp[(k < 5) ? k : 4]);
         if (k >= 5) cmd_valid = 1'b0;
         cycle();
         if (m_acc) k++;
      end
      chk("bp_accepted", k, 5);
      cmd_valid = 1'b1;
      cycle();
      chk("bp_cmd_ready_low", cmd_ready, 0);
      chk("bp_res_stable", rsp_res, calc(bp[0]));
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin
         chk("bp_drain_valid", rsp_valid, 1);
         chk("bp_drain_res", rsp_res, calc(bp[j]));
         cycle();
      end
      chk("bp_drain_end", rsp_valid, 0);

      // Streaming: 16 back-to-back commands, one result per cycle.
      d0 = done_cnt;
      for (int i = 0; i < 16; i++) begin
         st[i] = rand_cmd();
         set_cmd(1'b1, st[i]);
         cycle();
         if (i >= 1) begin
            chk("stream_valid", rsp_valid, 1);
            chk("stream_res", rsp_res, calc(st[i-1]));
         end
      end
      cmd_valid = 1'b0;
      cycle();
      chk("stream_last", rsp_res, calc(st[15]));
      cycle();
      chk("stream_idle", rsp_valid, 0);
      chk("stream_done", done_cnt, d0 + 16'd16);

      // Flush with pending result and 3 buffered commands, coincident consume.
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bp[i] = rand_cmd();
         set_cmd(1'b1, bp[i]);
         cycle();
      end
      cmd_valid = 1'b0;
      chk("fl_pre_head", op_x, bp[1].a);
      d0 = done_cnt;
      flush = 1'b1; rsp_ready = 1'b1; cmd_valid = 1'b1;
      cycle();
      flush = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
      chk("fl_rsp_valid", rsp_valid, 0);
      chk("fl_cmd_ready", cmd_ready, 1);
      chk("fl_op_x", op_x, 0);
      chk("fl_done_kept", done_cnt, d0 + 16'd1);

      // Asynchronous reset between edges mid-run.
      for (int i = 0; i < 4; i++) begin
         set_cmd(1'b1, rand_cmd());
         cycle();
      end
      cmd_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_rsp_valid", rsp_valid, 0);
      chk("arst_cmd_ready", cmd_ready, 1);
      chk("arst_done_cnt", done_cnt, 0);
      chk("arst_op_x", op_x, 0);
      model_reset();
      rst = 1'b0;
      @(negedge clk);
      rsp_ready = 1'b1;
      c = rand_cmd();
      set_cmd(1'b1, c);
      cycle();
      cmd_valid = 1'b0;
      cycle();
      chk("post_rst_valid", rsp_valid, 1);
      chk("post_rst_res", rsp_res, calc(c));
      cycle();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         set_cmd($urandom_range(0, 3) != 0, rand_cmd());
         rsp_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 29) == 0);
         cycle();
      end
      flush = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) cycle();

      // Counter wrap: 65536 results consumed from reset.
      rst = 1'b1;
      #1 model_reset();
      rst = 1'b0;
      @(negedge clk);
      rsp_ready = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         set_cmd(1'b1, rand_cmd());
         cycle();
      end
      cmd_valid = 1'b0;
      cycle();
      cycle();
      chk("wrap_idle", rsp_valid, 0);
      chk("wrap_done_cnt", done_cnt, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
